// File: rtl/pkt_inj_pkg.sv
// Shared types and constants for the MMIO packet injector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pkt_inj_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_HDR,
        S_FETCH,
        S_LOAD,
        S_SEND,
        S_DONE
    } inj_state_t;

    localparam logic [31:0] REG_ADDR   = 32'd0;
    localparam logic [31:0] REG_NBYTES = 32'd4;
    localparam logic [31:0] REG_TIMER  = 32'd8;
    localparam logic [31:0] REG_STATUS = 32'd12;

    localparam int WORD_BYTES = 4;

    // ceil(nbytes / WORD_BYTES) on 17 bits so 16'hFFFF + 3 cannot overflow
    function automatic logic [16:0] word_count(input logic [15:0] nbytes);
        logic [16:0] sum;
        sum = {1'b0, nbytes} + 17'(WORD_BYTES - 1);
        return sum >> 2;
    endfunction

endpackage

// File: rtl/inj_countdown.sv
// 32-bit loadable down-counter with a zero flag, used for the pre-send delay.
// Latency: count updates one cycle after load/dec; zero is combinational on count.
// Backpressure: none; dec is ignored once the count reaches zero.
module inj_countdown (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        dec,
    output logic [31:0] count,
    output logic        zero
);

    // load has priority over decrement; the counter saturates at zero
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= 32'd0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != 32'd0)) begin
            count <= count - 32'd1;
        end
    end

    assign zero = (count == 32'd0);

endmodule

// File: rtl/mmio_pkt_injector.sv
// MMIO-programmed DMA that reads a memory block and emits it as flits (optional header via PKT_INJ_HEADER_EN).
// Latency: TIMER+2 cycles from TIMER write to header (TIMER+4 to first payload without header); 3 cycles per payload flit.
// Backpressure: flit_valid/flit_data hold until flit_ready; no new memory read is issued while a flit is stalled.
module mmio_pkt_injector
    import pkt_inj_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int          FLIT_W    = 32   // only 32 is supported
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       mmio_addr_in,
    input  logic [31:0]       mmio_data_in,
    input  logic              mmio_wb_in,
    output logic              irq,
    output logic              mem_rd,
    output logic [31:0]       mem_addr,
    input  logic [FLIT_W-1:0] mem_data,
    output logic              flit_valid,
    output logic [FLIT_W-1:0] flit_data,
    input  logic              flit_ready
);

    inj_state_t        state_q;
    inj_state_t        state_d;
    logic [31:0]       addr_q;
    logic [15:0]       nbytes_q;
    logic [16:0]       words_left_q;
    logic [FLIT_W-1:0] flit_q;
    logic              irq_q;
    logic              cnt_zero;
    logic [31:0]       cnt_value;

    logic wr_addr;
    logic wr_nbytes;
    logic wr_timer;
    logic wr_status;
    logic in_idle;

    assign wr_addr   = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_ADDR);
    assign wr_nbytes = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_NBYTES);
    assign wr_timer  = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_TIMER);
    assign wr_status = mmio_wb_in && (mmio_addr_in == BASE_ADDR + REG_STATUS);
    assign in_idle   = (state_q == S_IDLE);

    inj_countdown u_countdown (
        .clock      (clock),
        .reset      (reset),
        .load       (wr_timer && in_idle),
        .load_value (mmio_data_in),
        .dec        (state_q == S_WAIT),
        .count      (cnt_value),
        .zero       (cnt_zero)
    );

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next-state logic and the handshake/read strobes that depend only on state
    always_comb begin
        state_d    = state_q;
        flit_valid = 1'b0;
        mem_rd     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_timer) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
`ifdef PKT_INJ_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = (words_left_q == 17'd0) ? S_DONE : S_FETCH;
`endif
                end
            end
            S_HDR: begin
                flit_valid = 1'b1;
                if (flit_ready) begin
                    state_d = (words_left_q == 17'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd  = 1'b1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                state_d = S_SEND;
            end
            S_SEND: begin
                flit_valid = 1'b1;
                if (flit_ready) begin
                    state_d = (words_left_q == 17'd1) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // register file, transfer bookkeeping, flit holding register and irq
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q       <= 32'd0;
            nbytes_q     <= 16'd0;
            words_left_q <= 17'd0;
            flit_q       <= '0;
            irq_q        <= 1'b0;
        end else begin
            // configuration is frozen while a transfer is in flight
            if (in_idle && wr_addr) begin
                addr_q <= {mmio_data_in[31:2], 2'b00};
            end
            if (in_idle && wr_nbytes) begin
                nbytes_q <= mmio_data_in[15:0];
            end
            if (in_idle && wr_timer) begin
                words_left_q <= word_count(nbytes_q);
            end
`ifdef PKT_INJ_HEADER_EN
            if ((state_q == S_WAIT) && cnt_zero) begin
                flit_q <= {16'h0, nbytes_q};
            end
`endif
            // memory data is valid only in the cycle after the read strobe
            if (state_q == S_LOAD) begin
                flit_q <= mem_data;
            end
            if ((state_q == S_SEND) && flit_ready) begin
                addr_q       <= addr_q + 32'd4;
                words_left_q <= words_left_q - 17'd1;
            end
            // setting wins over a simultaneous STATUS clear
            if (state_q == S_DONE) begin
                irq_q <= 1'b1;
            end else if (wr_status) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq       = irq_q;
    assign mem_addr  = addr_q;
    assign flit_data = flit_q;

endmodule

// File: tb/tb_mmio_pkt_injector.sv
// Randomized self-checking bench for mmio_pkt_injector against a transfer-level reference model.
// Latency: n/a.
// Backpressure: flit_ready driven constant, random or held low to exercise stalls.
module tb_mmio_pkt_injector;

    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef PKT_INJ_HEADER_EN
    localparam int H = 1;
`else
    localparam int H = 0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] mmio_addr_in = 32'd0;
    logic [31:0] mmio_data_in = 32'd0;
    logic        mmio_wb_in = 1'b0;
    logic        irq;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_data = 32'd0;
    logic        flit_valid;
    logic [31:0] flit_data;
    logic        flit_ready = 1'b0;

    mmio_pkt_injector #(.BASE_ADDR(BASE), .FLIT_W(32)) dut (
        .clock        (clock),
        .reset        (reset),
        .mmio_addr_in (mmio_addr_in),
        .mmio_data_in (mmio_data_in),
        .mmio_wb_in   (mmio_wb_in),
        .irq          (irq),
        .mem_rd       (mem_rd),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .flit_valid   (flit_valid),
        .flit_data    (flit_data),
        .flit_ready   (flit_ready)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int ready_mode = 1;   // 0: low, 1: high, 2: random

    logic [31:0] acc_q[$];
    logic [31:0] rd_q[$];
    int          rise_q[$];
    int          irq_rise_q[$];
    int          stall_cnt = 0;
    int          stall_viol = 0;
    logic        prev_valid = 1'b0;
    logic        prev_irq = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = 32'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // memory: data valid only in the cycle after a read strobe, junk otherwise
    always @(posedge clock) mem_data <= mem_rd ? mem_word(mem_addr) : $urandom;

    // flit_ready driver
    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       flit_ready = 1'b0;
                1:       flit_ready = 1'b1;
                default: flit_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // observe handshakes, reads, rising edges and hold-while-stalled behaviour
    always @(negedge clock) begin
        if (!reset) begin
            if (flit_valid && flit_ready) acc_q.push_back(flit_data);
            if (mem_rd) rd_q.push_back(mem_addr);
            if (flit_valid && !prev_valid) rise_q.push_back(cyc);
            if (irq && !prev_irq) irq_rise_q.push_back(cyc);
            if (prev_stall && (!flit_valid || (flit_data !== prev_data))) stall_viol <= stall_viol + 1;
            if (flit_valid && !flit_ready) stall_cnt <= stall_cnt + 1;
        end
        prev_valid <= flit_valid;
        prev_irq   <= irq;
        prev_stall <= flit_valid && !flit_ready && !reset;
        prev_data  <= flit_data;
    end

    task automatic sync();
        @(posedge clock);
        #1;
    endtask

    task automatic mmio_write(input logic [31:0] off, input logic [31:0] d);
        mmio_addr_in = BASE + off;
        mmio_data_in = d;
        mmio_wb_in   = 1'b1;
        sync();
        mmio_wb_in   = 1'b0;
    endtask

    task automatic run_xfer(input logic [31:0] a, input logic [15:0] nb, input int t,
                            input int mode, input bit stall, input bit disturb, input bit setwins);
        int w, acc_b, rd_b, rise_b, irq_b, viol_b, stall_b, c_t, done_c, n0;
        bit got;
        logic [31:0] base_a, d, exp;
        w      = (int'(nb) + 3) / 4;
        base_a = a & 32'hFFFF_FFFC;
        ready_mode = mode;
        sync();
        mmio_write(32'd0, a);
        d = $urandom;
        d[15:0] = nb;
        mmio_write(32'd4, d);
        acc_b = acc_q.size(); rd_b = rd_q.size(); rise_b = rise_q.size();
        irq_b = irq_rise_q.size(); viol_b = stall_viol;
        c_t = cyc;
        mmio_write(32'd8, t);
        done_c = c_t + t + 2 + 3 * w + H;
        if (disturb) begin
            mmio_write(32'd0, $urandom);
            mmio_write(32'd4, $urandom);
            mmio_write(32'd8, 32'd999);
        end
        if (setwins) begin
            while (cyc < done_c) sync();
            mmio_write(32'd12, 32'd0);
        end
        if (stall && (w > 0)) begin
            got = 0;
            for (int i = 0; i < t + 200 && !got; i++) begin
                @(negedge clock); #1;
                got = (rd_q.size() > rd_b);
            end
            ready_mode = 0;
            for (int i = 0; i < 20 && !(got && flit_valid && !flit_ready); i++) begin
                @(negedge clock); #1;
            end
            check("stall_reached", 32'(got && flit_valid && !flit_ready), 32'd1);
            n0 = rd_q.size();
            stall_b = stall_cnt;
            repeat (5) begin
                @(negedge clock); #1;
            end
            check("stall_valid", 32'(flit_valid), 32'd1);
            check("stall_no_rd", rd_q.size(), n0);
            check("stall_cycles", stall_cnt - stall_b, 5);
            ready_mode = 1;
        end
        got = 0;
        for (int i = 0; i < t + 100 * (w + 1) + 200 && !got; i++) begin
            @(negedge clock); #1;
            got = irq;
        end
        check("irq_set", 32'(got), 32'd1);
        if (w + H > 0)
            check("first_valid_lat", (rise_q.size() > rise_b) ? rise_q[rise_b] - c_t : -1, t + 2 + 2 * (1 - H));
        check("n_flits", acc_q.size() - acc_b, w + H);
        for (int i = 0; i < w + H; i++) begin
            exp = (H == 1 && i == 0) ? {16'h0, nb} : mem_word(base_a + 32'(4 * (i - H)));
            if (acc_b + i < acc_q.size()) check("flit_data", acc_q[acc_b + i], exp);
        end
        check("n_reads", rd_q.size() - rd_b, w);
        for (int i = 0; i < w; i++) begin
            if (rd_b + i < rd_q.size()) check("rd_addr", rd_q[rd_b + i], base_a + 32'(4 * i));
        end
        check("hold_stable", stall_viol - viol_b, 0);
        if (mode == 1 && !stall)
            check("irq_lat", (irq_rise_q.size() > irq_b) ? irq_rise_q[irq_b] : -1, done_c + 1);
        sync();
        mmio_write(32'd12, $urandom);
        check("irq_clear", 32'(irq), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_n, rd_n, acc_b;
        bit got;
        logic [31:0] ra;
        logic [15:0] rn;
        int rt;

        repeat (3) sync();
        @(negedge clock); #1;
        check("rst_valid", 32'(flit_valid), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_mem_rd", 32'(mem_rd), 32'd0);
        check("rst_flit_data", flit_data, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        sync();
        reset = 1'b0;

        run_xfer(32'h0001_0930, 16'd12, 30, 1, 1'b0, 1'b0, 1'b0);
        run_xfer(32'h2000_0043, 16'd5, 0, 1, 1'b0, 1'b0, 1'b0);
        run_xfer(32'h3000_0000, 16'd0, 7, 1, 1'b0, 1'b0, 1'b0);
        run_xfer(32'h4000_0100, 16'd16, 2, 1, 1'b1, 1'b0, 1'b0);
        run_xfer(32'h5000_0200, 16'd12, 10, 1, 1'b0, 1'b1, 1'b0);
        run_xfer(32'hFFFF_FFF6, 16'd16, 1, 1, 1'b0, 1'b0, 1'b1);

        // abort a 4-word transfer after two accepted flits
        ready_mode = 1;
        sync();
        mmio_write(32'd0, 32'h6000_0000);
        mmio_write(32'd4, 32'd16);
        acc_b = acc_q.size();
        mmio_write(32'd8, 32'd3);
        got = 0;
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clock); #1;
            got = (acc_q.size() - acc_b >= 2);
        end
        check("rst_reach_2", 32'(got), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        sync();
        reset = 1'b0;
        @(negedge clock); #1;
        check("abort_valid", 32'(flit_valid), 32'd0);
        check("abort_irq", 32'(irq), 32'd0);
        check("abort_mem_addr", mem_addr, 32'd0);
        check("abort_flit_data", flit_data, 32'd0);
        acc_n = acc_q.size();
        rd_n  = rd_q.size();
        repeat (40) @(negedge clock);
        #1;
        check("abort_no_flits", acc_q.size(), acc_n);
        check("abort_no_reads", rd_q.size(), rd_n);
        check("abort_irq_low", 32'(irq), 32'd0);
        run_xfer(32'h0000_1000, 16'd8, 5, 1, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            if (k == 0) ra = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            rn = 16'($urandom_range(0, 30));
            rt = $urandom_range(0, 12);
            run_xfer(ra, rn, rt, 2, 1'b0, (rt >= 4), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
